// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: ar/r/aw/w/b channels, 32-bit address and data.
// The master modport drives requests; the slave modport answers them.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N:1 AXI4-Lite arbiter: independent round-robin read and write paths.
// Each path owns one grant until its response handshake completes.
module axi_lite_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    axi_lite_if.slave  m [NUM_MASTERS],
    axi_lite_if.master s
);
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } wr_state_t;

    rd_state_t     rd_state;
    wr_state_t     wr_state;
    logic [GW-1:0] rd_grant;
    logic [GW-1:0] rd_ptr;
    logic [GW-1:0] wr_grant;
    logic [GW-1:0] wr_ptr;
    logic          aw_done;
    logic          w_done;

    logic [NUM_MASTERS-1:0] ar_req;
    logic [NUM_MASTERS-1:0] aw_req;
    logic [NUM_MASTERS-1:0] m_rready;
    logic [NUM_MASTERS-1:0] m_wvalid;
    logic [NUM_MASTERS-1:0] m_bready;
    logic [31:0]            m_araddr [NUM_MASTERS];
    logic [31:0]            m_awaddr [NUM_MASTERS];
    logic [31:0]            m_wdata  [NUM_MASTERS];
    logic [3:0]             m_wmask  [NUM_MASTERS];

    logic rd_in_addr;
    logic rd_in_data;
    logic wr_in_addr;
    logic wr_in_resp;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    // First requester strictly after ptr, wrapping; lowest distance wins.
    function automatic logic [GW-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [GW-1:0]          ptr
    );
        logic [GW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (req[idx]) begin
                pick = GW'(idx);
            end
        end
        return pick;
    endfunction

    assign rd_in_addr = (rd_state == RD_ADDR);
    assign rd_in_data = (rd_state == RD_DATA);
    assign wr_in_addr = (wr_state == WR_ADDR);
    assign wr_in_resp = (wr_state == WR_RESP);

    // Per-master fan-out: only the granted master sees slave-side signals.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
        logic rd_sel;
        logic wr_sel;

        assign rd_sel = (rd_grant == GW'(g));
        assign wr_sel = (wr_grant == GW'(g));

        assign ar_req[g]   = m[g].arvalid;
        assign m_araddr[g] = m[g].araddr;
        assign m_rready[g] = m[g].rready;
        assign aw_req[g]   = m[g].awvalid;
        assign m_awaddr[g] = m[g].awaddr;
        assign m_wvalid[g] = m[g].wvalid;
        assign m_wdata[g]  = m[g].wdata;
        assign m_wmask[g]  = m[g].wmask;
        assign m_bready[g] = m[g].bready;

        assign m[g].arready = (rd_in_addr && rd_sel) ? s.arready : 1'b0;
        assign m[g].rvalid  = (rd_in_data && rd_sel) ? s.rvalid : 1'b0;
        assign m[g].rdata   = (rd_in_data && rd_sel) ? s.rdata : '0;
        assign m[g].rresp   = (rd_in_data && rd_sel) ? s.rresp : '0;

        assign m[g].awready = (wr_in_addr && wr_sel && !aw_done) ?
                              s.awready : 1'b0;
        assign m[g].wready  = (wr_in_addr && wr_sel && !w_done) ?
                              s.wready : 1'b0;
        assign m[g].bvalid  = (wr_in_resp && wr_sel) ? s.bvalid : 1'b0;
        assign m[g].bresp   = (wr_in_resp && wr_sel) ? s.bresp : '0;
    end

    assign s.arvalid = rd_in_addr ? ar_req[rd_grant] : 1'b0;
    assign s.araddr  = rd_in_addr ? m_araddr[rd_grant] : '0;
    assign s.rready  = rd_in_data ? m_rready[rd_grant] : 1'b0;

    // Each write channel goes quiet once its own handshake has happened.
    assign s.awvalid = (wr_in_addr && !aw_done) ? aw_req[wr_grant] : 1'b0;
    assign s.awaddr  = wr_in_addr ? m_awaddr[wr_grant] : '0;
    assign s.wvalid  = (wr_in_addr && !w_done) ? m_wvalid[wr_grant] : 1'b0;
    assign s.wdata   = wr_in_addr ? m_wdata[wr_grant] : '0;
    assign s.wmask   = wr_in_addr ? m_wmask[wr_grant] : '0;
    assign s.bready  = wr_in_resp ? m_bready[wr_grant] : 1'b0;

    assign ar_hs = s.arvalid && s.arready;
    assign r_hs  = s.rvalid && s.rready;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid && s.wready;
    assign b_hs  = s.bvalid && s.bready;

    // Read path: arbitrate, forward AR, forward R, then release the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            rd_grant <= '0;
            rd_ptr   <= GW'(NUM_MASTERS - 1);
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (|ar_req) begin
                        rd_grant <= rr_pick(ar_req, rd_ptr);
                        rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rd_state <= RD_IDLE;
                        rd_ptr   <= rd_grant;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write path: AW and W complete in either order before B is forwarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= WR_IDLE;
            wr_grant <= '0;
            wr_ptr   <= GW'(NUM_MASTERS - 1);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (|aw_req) begin
                        wr_grant <= rr_pick(aw_req, wr_ptr);
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        wr_state <= WR_IDLE;
                        wr_ptr   <= wr_grant;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level ownership model.
module tb_axi_lite_arbiter;
    localparam int NM = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    axi_lite_if m_if [NM] ();
    axi_lite_if s_if ();

    axi_lite_arbiter #(.NUM_MASTERS(NM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m       (m_if),
        .s       (s_if)
    );

    logic        t_arvalid [NM];
    logic [31:0] t_araddr  [NM];
    logic        t_rready  [NM];
    logic        t_awvalid [NM];
    logic [31:0] t_awaddr  [NM];
    logic        t_wvalid  [NM];
    logic [31:0] t_wdata   [NM];
    logic [3:0]  t_wmask   [NM];
    logic        t_bready  [NM];

    logic        o_arready [NM];
    logic        o_rvalid  [NM];
    logic [31:0] o_rdata   [NM];
    logic [1:0]  o_rresp   [NM];
    logic        o_awready [NM];
    logic        o_wready  [NM];
    logic        o_bvalid  [NM];
    logic [1:0]  o_bresp   [NM];

    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awready;
    logic        s_wready;
    logic        s_bvalid;
    logic [1:0]  s_bresp;

    for (genvar g = 0; g < NM; g++) begin : g_conn
        assign m_if[g].arvalid = t_arvalid[g];
        assign m_if[g].araddr  = t_araddr[g];
        assign m_if[g].rready  = t_rready[g];
        assign m_if[g].awvalid = t_awvalid[g];
        assign m_if[g].awaddr  = t_awaddr[g];
        assign m_if[g].wvalid  = t_wvalid[g];
        assign m_if[g].wdata   = t_wdata[g];
        assign m_if[g].wmask   = t_wmask[g];
        assign m_if[g].bready  = t_bready[g];
        assign o_arready[g] = m_if[g].arready;
        assign o_rvalid[g]  = m_if[g].rvalid;
        assign o_rdata[g]   = m_if[g].rdata;
        assign o_rresp[g]   = m_if[g].rresp;
        assign o_awready[g] = m_if[g].awready;
        assign o_wready[g]  = m_if[g].wready;
        assign o_bvalid[g]  = m_if[g].bvalid;
        assign o_bresp[g]   = m_if[g].bresp;
    end

    assign s_if.arready = s_arready;
    assign s_if.rvalid  = s_rvalid;
    assign s_if.rdata   = s_rdata;
    assign s_if.rresp   = s_rresp;
    assign s_if.awready = s_awready;
    assign s_if.wready  = s_wready;
    assign s_if.bvalid  = s_bvalid;
    assign s_if.bresp   = s_bresp;

    // Model: which master owns each path (-1 none) and in which phase.
    int rd_own, rd_ph, rd_last;
    int wr_own, wr_ph, wr_last;
    bit aw_d, w_d;
    int n_cmp, n_bad;
    int gq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int rr(input bit [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rd_own  = -1;
        wr_own  = -1;
        rd_ph   = 0;
        wr_ph   = 0;
        rd_last = NM - 1;
        wr_last = NM - 1;
        aw_d    = 1'b0;
        w_d     = 1'b0;
    endtask

    task automatic clear();
        for (int i = 0; i < NM; i++) begin
            t_arvalid[i] = 1'b0;
            t_araddr[i]  = '0;
            t_rready[i]  = 1'b0;
            t_awvalid[i] = 1'b0;
            t_awaddr[i]  = '0;
            t_wvalid[i]  = 1'b0;
            t_wdata[i]   = '0;
            t_wmask[i]   = '0;
            t_bready[i]  = 1'b0;
        end
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = '0;
    endtask

    // Called just after a falling edge with inputs settled: compare all
    // outputs with the model, advance the model, wait for the next fall.
    task automatic step();
        bit          ra, rd, wa, wb;
        int          ri, wi, g;
        logic        e_arv, e_rr, e_awv, e_wv, e_br;
        bit [NM-1:0] arq, awq;
        #1;
        ri = (rd_own < 0) ? 0 : rd_own;
        wi = (wr_own < 0) ? 0 : wr_own;
        ra = (rd_own >= 0) && (rd_ph == 0);
        rd = (rd_own >= 0) && (rd_ph == 1);
        wa = (wr_own >= 0) && (wr_ph == 0);
        wb = (wr_own >= 0) && (wr_ph == 1);
        e_arv = ra ? t_arvalid[ri] : 1'b0;
        e_rr  = rd ? t_rready[ri] : 1'b0;
        e_awv = (wa && !aw_d) ? t_awvalid[wi] : 1'b0;
        e_wv  = (wa && !w_d) ? t_wvalid[wi] : 1'b0;
        e_br  = wb ? t_bready[wi] : 1'b0;

        chk1("s.arvalid", s_if.arvalid, e_arv);
        chk1("s.rready", s_if.rready, e_rr);
        chk1("s.awvalid", s_if.awvalid, e_awv);
        chk1("s.wvalid", s_if.wvalid, e_wv);
        chk1("s.bready", s_if.bready, e_br);
        if (!rd) chk("s.araddr", s_if.araddr, ra ? t_araddr[ri] : 32'h0);
        if (!wb) begin
            chk("s.awaddr", s_if.awaddr, wa ? t_awaddr[wi] : 32'h0);
            chk("s.wdata", s_if.wdata, wa ? t_wdata[wi] : 32'h0);
            chk("s.wmask", 32'(s_if.wmask), wa ? 32'(t_wmask[wi]) : 32'h0);
        end
        for (int i = 0; i < NM; i++) begin
            chk1($sformatf("m%0d.arready", i), o_arready[i],
                 (ra && i == rd_own) ? s_arready : 1'b0);
            chk1($sformatf("m%0d.rvalid", i), o_rvalid[i],
                 (rd && i == rd_own) ? s_rvalid : 1'b0);
            chk1($sformatf("m%0d.awready", i), o_awready[i],
                 (wa && i == wr_own && !aw_d) ? s_awready : 1'b0);
            chk1($sformatf("m%0d.wready", i), o_wready[i],
                 (wa && i == wr_own && !w_d) ? s_wready : 1'b0);
            chk1($sformatf("m%0d.bvalid", i), o_bvalid[i],
                 (wb && i == wr_own) ? s_bvalid : 1'b0);
            if (i != rd_own || rd) begin
                chk($sformatf("m%0d.rdata", i), o_rdata[i],
                    (i == rd_own) ? s_rdata : 32'h0);
                chk($sformatf("m%0d.rresp", i), 32'(o_rresp[i]),
                    (i == rd_own) ? 32'(s_rresp) : 32'h0);
            end
            if (i != wr_own || wb) begin
                chk($sformatf("m%0d.bresp", i), 32'(o_bresp[i]),
                    (i == wr_own) ? 32'(s_bresp) : 32'h0);
            end
        end

        if (reset_n) begin
            for (int i = 0; i < NM; i++) begin
                arq[i] = t_arvalid[i];
                awq[i] = t_awvalid[i];
            end
            if (rd_own < 0) begin
                g = rr(arq, rd_last);
                if (g >= 0) begin
                    rd_own = g;
                    rd_ph  = 0;
                end
            end else if (ra) begin
                if (e_arv && s_arready) rd_ph = 1;
            end else if (s_rvalid && e_rr) begin
                rd_last = rd_own;
                rd_own  = -1;
            end
            if (wr_own < 0) begin
                g = rr(awq, wr_last);
                if (g >= 0) begin
                    wr_own = g;
                    wr_ph  = 0;
                    aw_d   = 1'b0;
                    w_d    = 1'b0;
                end
            end else if (wa) begin
                if (e_awv && s_awready) aw_d = 1'b1;
                if (e_wv && s_wready) w_d = 1'b1;
                if (aw_d && w_d) wr_ph = 1;
            end else if (s_bvalid && e_br) begin
                wr_last = wr_own;
                wr_own  = -1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset holds every path quiet even with requests pending.
        t_arvalid[0] = 1'b1;
        t_awvalid[1] = 1'b1;
        t_wvalid[1]  = 1'b1;
        s_rvalid     = 1'b1;
        s_bvalid     = 1'b1;
        #1;
        chk1("rst s.arvalid", s_if.arvalid, 1'b0);
        chk1("rst s.awvalid", s_if.awvalid, 1'b0);
        chk1("rst m0.rvalid", o_rvalid[0], 1'b0);
        step();
        step();
        clear();
        reset_n = 1'b1;
        step();

        // Single read from m1.
        t_arvalid[1] = 1'b1;
        t_araddr[1]  = 32'h8000_0010;
        #1 chk1("rd1 idle s.arvalid", s_if.arvalid, 1'b0);
        step();
        s_arready = 1'b1;
        #1;
        chk("rd1 s.araddr", s_if.araddr, 32'h8000_0010);
        chk1("rd1 m1.arready", o_arready[1], 1'b1);
        chk1("rd1 m0.arready", o_arready[0], 1'b0);
        step();
        t_arvalid[1] = 1'b0;
        s_arready    = 1'b0;
        s_rvalid     = 1'b1;
        s_rdata      = 32'hDEAD_BEEF;
        t_rready[0]  = 1'b1;
        t_rready[1]  = 1'b1;
        #1;
        chk1("rd1 m1.rvalid", o_rvalid[1], 1'b1);
        chk("rd1 m1.rdata", o_rdata[1], 32'hDEAD_BEEF);
        chk("rd1 m1.rresp", 32'(o_rresp[1]), 32'h0);
        chk1("rd1 m0.rvalid", o_rvalid[0], 1'b0);
        step();
        clear();
        step();

        // Contention: m0 then m1, one idle cycle between.
        t_arvalid[0] = 1'b1;
        t_araddr[0]  = 32'h8000_0000;
        t_arvalid[1] = 1'b1;
        t_araddr[1]  = 32'h8000_0004;
        t_rready[0]  = 1'b1;
        t_rready[1]  = 1'b1;
        step();
        s_arready = 1'b1;
        #1 chk("cont first addr", s_if.araddr, 32'h8000_0000);
        step();
        t_arvalid[0] = 1'b0;
        s_arready    = 1'b0;
        s_rvalid     = 1'b1;
        s_rdata      = 32'h1111_1111;
        #1;
        chk("cont m0.rdata", o_rdata[0], 32'h1111_1111);
        chk1("cont m1.rvalid", o_rvalid[1], 1'b0);
        step();
        s_rvalid = 1'b0;
        #1 chk1("cont gap s.arvalid", s_if.arvalid, 1'b0);
        step();
        s_arready = 1'b1;
        #1 chk("cont second addr", s_if.araddr, 32'h8000_0004);
        step();
        t_arvalid[1] = 1'b0;
        s_arready    = 1'b0;
        s_rvalid     = 1'b1;
        s_rdata      = 32'h2222_2222;
        #1 chk("cont m1.rdata", o_rdata[1], 32'h2222_2222);
        step();
        clear();
        step();

        // Fairness: both masters request continuously for six reads.
        t_arvalid[0] = 1'b1;
        t_araddr[0]  = 32'h8000_0100;
        t_arvalid[1] = 1'b1;
        t_araddr[1]  = 32'h8000_0200;
        t_rready[0]  = 1'b1;
        t_rready[1]  = 1'b1;
        s_arready    = 1'b1;
        s_rvalid     = 1'b1;
        s_rdata      = 32'h5A5A_0000;
        gq.delete();
        for (int c = 0; c < 18; c++) begin
            #1;
            for (int i = 0; i < NM; i++) begin
                if (o_arready[i]) gq.push_back(i);
            end
            step();
        end
        chk("fair grant count", gq.size(), 6);
        for (int k = 0; k < 6 && k < gq.size(); k++) begin
            chk($sformatf("fair grant %0d", k), gq[k], k % 2);
        end
        clear();
        step();

        // Write with W presented two cycles before AW.
        t_wvalid[0] = 1'b1;
        t_wdata[0]  = 32'h1234_5678;
        t_wmask[0]  = 4'hF;
        s_awready   = 1'b1;
        s_wready    = 1'b1;
        #1 chk1("wr early s.wvalid", s_if.wvalid, 1'b0);
        step();
        step();
        t_awvalid[0] = 1'b1;
        t_awaddr[0]  = 32'hA000_03F8;
        #1 chk1("wr idle s.awvalid", s_if.awvalid, 1'b0);
        step();
        s_awready = 1'b0;
        #1;
        chk1("wr s.awvalid", s_if.awvalid, 1'b1);
        chk("wr s.awaddr", s_if.awaddr, 32'hA000_03F8);
        chk("wr s.wdata", s_if.wdata, 32'h1234_5678);
        chk("wr s.wmask", 32'(s_if.wmask), 32'hF);
        chk1("wr m0.wready", o_wready[0], 1'b1);
        step();
        s_awready   = 1'b1;
        s_bvalid    = 1'b1;
        t_bready[0] = 1'b1;
        t_bready[1] = 1'b1;
        #1;
        chk1("wr gated s.wvalid", s_if.wvalid, 1'b0);
        chk1("wr early m0.bvalid", o_bvalid[0], 1'b0);
        step();
        t_awvalid[0] = 1'b0;
        t_wvalid[0]  = 1'b0;
        #1;
        chk1("wr m0.bvalid", o_bvalid[0], 1'b1);
        chk1("wr m1.bvalid", o_bvalid[1], 1'b0);
        chk1("wr resp s.awvalid", s_if.awvalid, 1'b0);
        step();
        clear();
        step();

        // Concurrent read from m0 and write from m1.
        t_arvalid[0] = 1'b1;
        t_araddr[0]  = 32'h8000_0040;
        t_rready[0]  = 1'b1;
        t_awvalid[1] = 1'b1;
        t_awaddr[1]  = 32'hA000_0040;
        t_wvalid[1]  = 1'b1;
        t_wdata[1]   = 32'hCAFE_F00D;
        t_wmask[1]   = 4'h3;
        t_bready[1]  = 1'b1;
        s_arready    = 1'b1;
        s_awready    = 1'b1;
        s_wready     = 1'b1;
        step();
        #1;
        chk("conc s.araddr", s_if.araddr, 32'h8000_0040);
        chk("conc s.awaddr", s_if.awaddr, 32'hA000_0040);
        step();
        clear();
        t_rready[0] = 1'b1;
        t_bready[1] = 1'b1;
        s_rvalid    = 1'b1;
        s_rdata     = 32'h0BAD_F00D;
        s_bvalid    = 1'b1;
        s_bresp     = 2'b10;
        #1;
        chk("conc m0.rdata", o_rdata[0], 32'h0BAD_F00D);
        chk1("conc m1.bvalid", o_bvalid[1], 1'b1);
        chk("conc m1.bresp", 32'(o_bresp[1]), 32'h2);
        chk1("conc m1.rvalid", o_rvalid[1], 1'b0);
        chk1("conc m0.bvalid", o_bvalid[0], 1'b0);
        step();
        clear();
        step();

        // Reset while m0 sits in its data phase.
        t_arvalid[0] = 1'b1;
        t_araddr[0]  = 32'h8000_0080;
        s_arready    = 1'b1;
        step();
        step();
        t_arvalid[0] = 1'b0;
        s_arready    = 1'b0;
        s_rvalid     = 1'b1;
        s_rdata      = 32'h7777_7777;
        #1 chk1("rst-mid m0.rvalid before", o_rvalid[0], 1'b1);
        reset_n = 1'b0;
        model_reset();
        #1 chk1("rst-mid m0.rvalid after", o_rvalid[0], 1'b0);
        step();
        clear();
        reset_n      = 1'b1;
        t_arvalid[1] = 1'b1;
        t_araddr[1]  = 32'h8000_0300;
        step();
        s_arready = 1'b1;
        #1;
        chk1("rst-mid m1.arready", o_arready[1], 1'b1);
        chk("rst-mid s.araddr", s_if.araddr, 32'h8000_0300);
        step();
        clear();
        step();

        // Random traffic, including protocol abuse and stray resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                t_arvalid[i] = ($urandom_range(0, 9) < 5);
                t_araddr[i]  = $urandom;
                t_rready[i]  = ($urandom_range(0, 9) < 7);
                t_awvalid[i] = ($urandom_range(0, 9) < 5);
                t_awaddr[i]  = $urandom;
                t_wvalid[i]  = ($urandom_range(0, 9) < 5);
                t_wdata[i]   = $urandom;
                t_wmask[i]   = 4'($urandom);
                t_bready[i]  = ($urandom_range(0, 9) < 7);
            end
            s_arready = ($urandom_range(0, 9) < 6);
            s_rvalid  = ($urandom_range(0, 9) < 6);
            s_rdata   = $urandom;
            s_rresp   = 2'($urandom);
            s_awready = ($urandom_range(0, 9) < 6);
            s_wready  = ($urandom_range(0, 9) < 6);
            s_bvalid  = ($urandom_range(0, 9) < 6);
            s_bresp   = 2'($urandom);
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, giving the number of upstream AXI4-Lite masters (range 2..8).
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have m  axi_lite_if.slave  array[NUM_MASTERS]  upstream masters (ar/r/aw/w/b channels; 32-bit addr/data, wmask, 2-bit resp).
REQ-005 SHALL have s  axi_lite_if.master  1  single downstream slave port (typically the xbar's master-side input).

Function
REQ-006 SHALL arbitrate the read path and the write path independently, each with its own FSM, grant register and round-robin pointer.
REQ-007 Read FSM SHALL have states RD_IDLE, RD_ADDR, RD_DATA; write FSM SHALL have states WR_IDLE, WR_ADDR, WR_RESP.
REQ-008 RD_IDLE: if any m[i].arvalid, SHALL register rd_grant = first requester at or after rd_ptr+1 (mod NUM_MASTERS) and go to RD_ADDR next cycle; else stay.
REQ-009 RD_ADDR: s.arvalid/araddr SHALL equal m[rd_grant].arvalid/araddr; m[rd_grant].arready SHALL equal s.arready; on s.arvalid&&s.arready go to RD_DATA.
REQ-010 RD_DATA: m[rd_grant].rvalid/rdata/rresp SHALL equal s.rvalid/rdata/rresp; s.rready SHALL equal m[rd_grant].rready; on s.rvalid&&s.rready go to RD_IDLE and set rd_ptr = rd_grant.
REQ-011 WR_IDLE: if any m[i].awvalid, SHALL register wr_grant by the same round-robin rule using wr_ptr, clear aw_done/w_done, go to WR_ADDR.
REQ-012 WR_ADDR: aw and w channels of m[wr_grant] SHALL be forwarded to s concurrently; each channel's valid SHALL be gated off once its done flag is set.
REQ-013 WR_ADDR: aw_done/w_done SHALL set on their respective handshakes; when both are set (including both in the same cycle) SHALL go to WR_RESP.
REQ-014 WR_RESP: b channel SHALL be forwarded between s and m[wr_grant]; on s.bvalid&&s.bready go to WR_IDLE and set wr_ptr = wr_grant.
REQ-015 Non-granted masters SHALL see arready, rvalid, awready, wready, bvalid = 0 and rdata = 0, rresp = 0, bresp = 0.
REQ-016 In RD_IDLE/WR_IDLE all s valid/ready outputs on that path SHALL be 0; address/data outputs SHALL be 0.
REQ-017 Minimum read latency SHALL be 1 cycle of arbitration plus slave latency; back-to-back transactions SHALL incur exactly one RD_IDLE/WR_IDLE cycle between them.
REQ-018 Grant SHALL be held until the response handshake completes, even if the granted master deasserts valid (protocol violation; no re-arbitration).
REQ-019 A read and a write SHALL be allowed in flight simultaneously, including from the same master.
REQ-020 Round-robin SHALL guarantee that with all masters requesting continuously each master is granted once per NUM_MASTERS transactions on that path.

Reset
REQ-021 On reset_n low SHALL immediately enter RD_IDLE and WR_IDLE, clear done flags, set rd_grant = wr_grant = 0 and rd_ptr = wr_ptr = NUM_MASTERS-1 (so master 0 wins first).
REQ-022 While reset_n is low all valid/ready outputs on m[] and s SHALL be 0; an in-flight transaction SHALL be abandoned without a response.
REQ-023 After reset_n deasserts, the first arbitration SHALL occur on the first rising clk edge with reset_n high.

Verification
REQ-024 Single read: m[1] araddr=0x80000010, slave returns rdata=0xDEADBEEF one cycle after AR handshake -> m[1] sees rvalid with 0xDEADBEEF, rresp=0; m[0] sees rvalid=0 throughout.
REQ-025 Contention after reset: m[0],m[1] arvalid together, addr 0x80000000/0x80000004 -> m[0] served first, m[1] second, exactly one idle cycle between, rd_ptr ends at 1.
REQ-026 Write with W before AW: m[0] wvalid(wdata=0x12345678, wmask=0xF) 2 cycles before awvalid(0xa00003f8) -> s sees both once, state WR_RESP only after both done, bresp=0 returned to m[0] only.
REQ-027 Concurrent paths: m[0] read while m[1] writes -> both complete independently, no stall of either path, data routed to the correct master.
REQ-028 Fairness: both masters issue 6 continuous reads -> grants alternate 0,1,0,1,0,1...; no master waits more than one transaction.
REQ-029 Reset mid-op: reset_n low while in RD_DATA with s.rvalid=1 -> m[*].rvalid drops immediately, FSM in RD_IDLE, next request from m[1] alone is granted correctly.
